// File: rtl/elevator_pkg.sv
// Shared key encodings, sim-state encodings and key helpers for the sim-control /
// settings-menu slice.
package elevator_pkg;

   typedef enum logic [3:0] {
      STOP   = 4'hA,
      RESUME = 4'hB,
      UP     = 4'hC,
      DOWN   = 4'hD,
      ESCAPE = 4'hE,
      ENTER  = 4'hF
   } button_t;

   typedef enum logic [1:0] {
      START  = 2'd0,
      SIM    = 2'd1,
      PAUSE  = 2'd2,
      ENDING = 2'd3
   } sim_state_t;

   function automatic logic is_digit(input logic [3:0] key);
      return (key <= 4'd9);
   endfunction

endpackage

// File: rtl/settings_menu_fsm_digit_accumulator.sv
// Saturating decimal digit accumulator: value <= min(value*10 + digit, limit).
module digit_accumulator #(
   parameter int VAL_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             push,
   input  logic [3:0]       digit,
   input  logic [VAL_W-1:0] limit,
   output logic [VAL_W-1:0] value,
   output logic             active
);

   localparam int TMP_W = VAL_W + 4;

   logic [VAL_W-1:0] value_reg;
   logic             active_reg;
   logic [TMP_W-1:0] tmp;
   logic [VAL_W-1:0] sat_value;

   // Four extra bits always hold (2^VAL_W-1)*10 + 9 without overflow.
   assign tmp       = ({4'b0, value_reg} * TMP_W'(10)) + TMP_W'(digit);
   assign sat_value = (tmp > {4'b0, limit}) ? limit : tmp[VAL_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_reg  <= '0;
         active_reg <= 1'b0;
      end else if (clr) begin
         value_reg  <= '0;
         active_reg <= 1'b0;
      end else if (push) begin
         value_reg  <= sat_value;
         active_reg <= 1'b1;
      end
   end

   assign value  = value_reg;
   assign active = active_reg;

endmodule

// File: rtl/settings_menu_fsm.sv
// Sim-control FSM plus a menu of NUM_SETTINGS saturating numeric settings, driven by
// rising edges of the keypad pressed level.
module settings_menu_fsm
   import elevator_pkg::*;
#(
   parameter int                            NUM_SETTINGS = 3,
   parameter int                            VAL_W        = 6,
   parameter int                            SET_W        = $clog2(NUM_SETTINGS),
   parameter logic [NUM_SETTINGS*VAL_W-1:0] MAX_VALS     = {6'd63, 6'd3, 6'd7},
   parameter logic [NUM_SETTINGS*VAL_W-1:0] RST_VALS     = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [3:0]                    buttonBus,
   input  logic                          pressed,
   output logic [1:0]                    simState,
   output logic [SET_W-1:0]              setting,
   output logic [NUM_SETTINGS*VAL_W-1:0] values,
   output logic [VAL_W-1:0]              entryValue,
   output logic                          entryActive,
   output logic                          commitPulse
);

   localparam logic [SET_W-1:0] LAST_IDX = SET_W'(NUM_SETTINGS - 1);

   sim_state_t       state_reg, state_next;
   logic             pressed_q_reg;
   logic [SET_W-1:0] setting_reg, setting_next;
   logic             commit_reg;
   logic [VAL_W-1:0] value_arr_reg [NUM_SETTINGS];
   logic [VAL_W-1:0] limit;
   logic [VAL_W-1:0] entry_value;
   logic             entry_active;
   logic             ev;
   logic             menu_ev;
   logic             acc_clr;
   logic             acc_push;
   logic             commit;

   assign ev      = pressed & ~pressed_q_reg;
   assign menu_ev = ev & (state_reg == START);

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         START:   if (ev && buttonBus == RESUME) state_next = SIM;
         SIM:     if (ev && buttonBus == STOP)   state_next = PAUSE;
         PAUSE: begin
            if (ev && buttonBus == RESUME)    state_next = SIM;
            else if (ev && buttonBus == STOP) state_next = ENDING;
         end
         ENDING:  if (ev && buttonBus == RESUME) state_next = START;
         default: state_next = START;
      endcase
   end

   always_comb begin
      setting_next = setting_reg;
      if (setting_reg > LAST_IDX)
         setting_next = '0;
      else if (menu_ev && buttonBus == UP)
         setting_next = (setting_reg == LAST_IDX) ? '0 : setting_reg + 1'b1;
      else if (menu_ev && buttonBus == DOWN)
         setting_next = (setting_reg == '0) ? LAST_IDX : setting_reg - 1'b1;
   end

   // Entry is also cleared on the edge that leaves START, so it reads 0 outside START.
   assign acc_push = menu_ev & is_digit(buttonBus);
   assign acc_clr  = (state_next != START)
                   | (menu_ev & (buttonBus == ENTER || buttonBus == ESCAPE ||
                                 buttonBus == UP    || buttonBus == DOWN));
   assign commit   = menu_ev & (buttonBus == ENTER) & entry_active;

   always_comb begin
      limit = '0;
      for (int i = 0; i < NUM_SETTINGS; i++)
         if (setting_reg == SET_W'(i)) limit = MAX_VALS[i*VAL_W +: VAL_W];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= START;
         pressed_q_reg <= 1'b0;
         setting_reg   <= '0;
         commit_reg    <= 1'b0;
      end else begin
         state_reg     <= state_next;
         pressed_q_reg <= pressed;
         setting_reg   <= setting_next;
         commit_reg    <= commit;
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_SETTINGS; gi++) begin : g_value
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               value_arr_reg[gi] <= RST_VALS[gi*VAL_W +: VAL_W];
            else if (commit && setting_reg == SET_W'(gi))
               value_arr_reg[gi] <= entry_value;
         end
         assign values[gi*VAL_W +: VAL_W] = value_arr_reg[gi];
      end
   endgenerate

   digit_accumulator #(.VAL_W(VAL_W)) u_acc (
      .clk    (clk),
      .rst    (rst),
      .clr    (acc_clr),
      .push   (acc_push),
      .digit  (buttonBus),
      .limit  (limit),
      .value  (entry_value),
      .active (entry_active)
   );

   assign simState    = state_reg;
   assign setting     = setting_reg;
   assign entryValue  = entry_value;
   assign entryActive = entry_active;
   assign commitPulse = commit_reg;

endmodule

// File: tb/tb_settings_menu_fsm.sv
// Scoreboard bench for settings_menu_fsm: a behavioural model pushes the expected outputs
// each cycle and they are popped and compared on the following falling edge.
module tb_settings_menu_fsm;
   import elevator_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  buttonBus = 4'd0;
   logic        pressed = 1'b0;
   logic [1:0]  simState;
   logic [1:0]  setting;
   logic [17:0] values;
   logic [5:0]  entryValue;
   logic        entryActive;
   logic        commitPulse;

   always #5 clk = ~clk;

   settings_menu_fsm dut (
      .clk         (clk),
      .rst         (rst),
      .buttonBus   (buttonBus),
      .pressed     (pressed),
      .simState    (simState),
      .setting     (setting),
      .values      (values),
      .entryValue  (entryValue),
      .entryActive (entryActive),
      .commitPulse (commitPulse)
   );

   typedef struct {
      int st;
      int set;
      int vals;
      int ent;
      int act;
      int pls;
   } snap_t;

   snap_t exp_q[$];
   int    tests_run    = 0;
   int    tests_failed = 0;

   int lim   [3] = '{7, 3, 63};
   int m_vals[3];
   int m_state, m_set, m_ent, m_act, m_pls;

   task automatic chk(input string tag, input int obs, input int exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_state = 0; m_set = 0; m_ent = 0; m_act = 0; m_pls = 0;
      for (int i = 0; i < 3; i++) m_vals[i] = 0;
   endfunction

   function automatic snap_t model_snap();
      snap_t s;
      s.st   = m_state;
      s.set  = m_set;
      s.vals = m_vals[0] + (m_vals[1] << 6) + (m_vals[2] << 12);
      s.ent  = m_ent;
      s.act  = m_act;
      s.pls  = m_pls;
      return s;
   endfunction

   function automatic void model_key(input int k);
      int tmp;
      m_pls = 0;
      if (m_state == 0) begin
         if (k <= 9) begin
            tmp   = m_ent * 10 + k;
            m_ent = (tmp > lim[m_set]) ? lim[m_set] : tmp;
            m_act = 1;
         end else if (k == 15) begin
            if (m_act == 1) begin
               m_vals[m_set] = m_ent;
               m_pls = 1;
            end
            m_ent = 0; m_act = 0;
         end else if (k == 14) begin
            m_ent = 0; m_act = 0;
         end else if (k == 12) begin
            m_set = (m_set + 1) % 3; m_ent = 0; m_act = 0;
         end else if (k == 13) begin
            m_set = (m_set + 2) % 3; m_ent = 0; m_act = 0;
         end
      end
      case (m_state)
         0: if (k == 11) m_state = 1;
         1: if (k == 10) m_state = 2;
         2: if (k == 10) m_state = 3; else if (k == 11) m_state = 1;
         3: if (k == 11) m_state = 0;
         default: m_state = 0;
      endcase
      if (m_state != 0) begin
         m_ent = 0; m_act = 0;
      end
   endfunction

   task automatic compare_snap(input string tag, input snap_t e);
      chk({tag, "_state"},   int'(simState),    e.st);
      chk({tag, "_setting"}, int'(setting),     e.set);
      chk({tag, "_values"},  int'(values),      e.vals);
      chk({tag, "_entry"},   int'(entryValue),  e.ent);
      chk({tag, "_active"},  int'(entryActive), e.act);
      chk({tag, "_pulse"},   int'(commitPulse), e.pls);
   endtask

   task automatic compare_next(input string tag);
      snap_t e;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         compare_snap(tag, e);
      end
   endtask

   // Press a key for 'hold' cycles, release for one; every cycle is scored.
   task automatic key(input string tag, input logic [3:0] k, input int hold);
      @(negedge clk);
      buttonBus = k;
      pressed   = 1'b1;
      model_key(int'(k));
      exp_q.push_back(model_snap());
      for (int i = 1; i < hold; i++) begin
         @(negedge clk);
         compare_next(tag);
         m_pls = 0;
         exp_q.push_back(model_snap());
      end
      @(negedge clk);
      compare_next(tag);
      pressed = 1'b0;
      m_pls   = 0;
      exp_q.push_back(model_snap());
      @(negedge clk);
      compare_next(tag);
      $display("[TB] key %h x%0d: state=%0d setting=%0d entry=%0d active=%0d values=%h",
               k, hold, simState, setting, entryValue, entryActive, values);
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      compare_snap("reset", model_snap());
      @(negedge clk);
      rst = 1'b1;

      // Setting 0 (limit 7): 5, ENTER -> values[0]=5, one-cycle pulse
      key("t1_d5", 4'd5, 1);
      key("t1_enter", ENTER, 1);
      key("t1_d9", 4'd9, 1);
      key("t1_enter_sat", ENTER, 1);

      // Setting 2 (limit 63): 4,2 -> 42; 9 -> 63; ENTER
      key("t2_up", UP, 1);
      key("t2_up2", UP, 1);
      key("t2_d4", 4'd4, 1);
      key("t2_d2", 4'd2, 1);
      key("t2_d9", 4'd9, 1);
      key("t2_enter", ENTER, 2);

      // Held key gives a single event; ESCAPE clears entry only
      key("t3_hold7", 4'd7, 20);
      key("t3_escape", ESCAPE, 1);

      // Wraparound of the index; ENTER with no digits
      key("t4_up_wrap", UP, 1);
      key("t4_down_wrap", DOWN, 1);
      key("t4_up_wrap2", UP, 1);
      key("t4_up_s1", UP, 1);
      key("t4_d8_lim3", 4'd8, 1);
      key("t4_enter_s1", ENTER, 1);
      key("t4_enter_empty", ENTER, 1);

      // Sim FSM walk; menu keys ignored outside START
      key("t5_d3", 4'd3, 1);
      key("t5_resume", RESUME, 1);
      key("t5_sim_digit", 4'd6, 1);
      key("t5_sim_up", UP, 1);
      key("t5_stop", STOP, 1);
      key("t5_pause_digit", 4'd2, 1);
      key("t5_pause_resume", RESUME, 1);
      key("t5_stop2", STOP, 1);
      key("t5_stop3", STOP, 1);
      key("t5_end_enter", ENTER, 1);
      key("t5_resume_start", RESUME, 1);

      // Asynchronous reset mid-entry
      key("t6_down", DOWN, 1);
      key("t6_d4", 4'd4, 1);
      key("t6_d2", 4'd2, 1);
      #2;
      rst = 1'b0;
      #1;
      model_reset();
      compare_snap("t6_async_rst", model_snap());
      @(negedge clk);
      compare_snap("t6_rst_hold", model_snap());
      rst = 1'b1;
      key("t6_after_d1", 4'd1, 1);

      chk("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
